control_display_frecuencia: RTL and testbench
=============================================

// Module: control_display_frecuencia
// PURPOSE
//  Controller for the frequency readout. Owns the 3-bit frequency index: it steps up/down on
//  button presses, saturates at 0..7, and drives indicadorFrecuencia into the frequency decoder.
//  Also time-multiplexes the decoder's four digit codes (n_0f..n_3f) onto a 4-digit
//  common-anode 7-segment display. Sits between the debounced board buttons, the decoder
//  and the display pins.
// PARAMETERS
//  REFRESH_CYCLES  50000  clk cycles each digit is lit (1 ms at 50 MHz); legal range >= 2
//  INIT_FREQ       3'd0   frequency index loaded on reset
// PORTS
//  clk                  in   1  system clock; all logic on rising edge
//  reset                in   1  synchronous, active-high reset
//  btn_up               in   1  debounced, synchronized level; rising edge = one step up
//  btn_down             in   1  debounced, synchronized level; rising edge = one step down
//  n_0f                 in   4  digit code, rightmost digit (0-9 = numeral, >=10 = blank)
//  n_1f                 in   4  digit code, digit 1
//  n_2f                 in   4  digit code, digit 2
//  n_3f                 in   4  digit code, leftmost digit
//  indicadorFrecuencia  out  3  current frequency index, registered
//  an                   out  4  digit anodes, active-low; an[0] = rightmost
//  seg                  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset (synchronous, active-high; clk and reset are the only clock/reset):
//   - Outputs: indicadorFrecuencia=INIT_FREQ, an=4'b1111, seg=7'b1111111.
//   - Internal state: refresh counter=0, digit pointer=0.
//   - Button history regs reset to 1. A button held through reset gives no step.
//   - Reset mid-scan or mid-press takes effect on the next edge; scan restarts from digit 0.
//  Edge detect:
//   - up_p = btn_up & ~btn_up_q; down_p = btn_down & ~btn_down_q.
//   - History regs update every cycle.
//   - A held button gives exactly one pulse.
//  Frequency index:
//   - up_p & ~down_p & idx<7 : idx+1.
//   - down_p & ~up_p & idx>0 : idx-1.
//   - Both pulses in the same cycle : hold.
//   - Saturating; never wraps 7->0 or 0->7.
//   - indicadorFrecuencia is the idx register itself, so it changes 1 cycle after the edge.
//  Scan:
//   - Refresh counter width $clog2(REFRESH_CYCLES); counts 0..REFRESH_CYCLES-1, then wraps to 0.
//   - On wrap the digit pointer advances 0->1->2->3->0.
//  Output register (updated every cycle, 1-cycle latency from pointer or digit code):
//   - an = all ones except an[ptr]=0.
//   - seg = decode(n_<ptr>f).
//   - Exactly one anode is low at any time outside reset.
//   - Codes >=10 give seg=7'b1111111 with the anode still asserted, so scan timing stays uniform.
//  Decode table (active-low gfedcba):
//   - 0=1000000  1=1111001  2=0100100  3=0110000  4=0011001
//   - 5=0010010  6=0000010  7=1111000  8=0000000  9=0010000
//  Decoder inputs are combinational from idx. A new index shows on the current digit within
//  2 cycles; no blanking, no scan restart.
// TESTING
//  1 Reset, INIT_FREQ=0, REFRESH_CYCLES=4 -> during reset an=1111, seg=1111111, ind=0;
//    first edge after release gives an=1110.
//  2 n_0f..n_3f = 2,5,10,1 -> an=1110/seg=0100100 for 4 cycles, then 1101/0010010,
//    then 1011/1111111, then 0111/1111001, then back to 1110.
//  3 Nine separate btn_up rising edges from idx=0 -> ind steps 1..7, then stays 7;
//    nine btn_down edges -> back to 0, then stays 0.
//  4 btn_up held high 100 cycles from idx=3 -> ind=4 exactly once, one cycle after the edge.
//  5 btn_up and btn_down rise on the same cycle at idx=4 -> ind stays 4.
//  6 reset asserted while ptr=2 and idx=5 -> next edge: ind=INIT_FREQ, an=1111;
//    after release the scan restarts at an=1110.

Source files
------------

// File: rtl/control_display_frecuencia.sv
// Frequency-index controller and 4-digit common-anode 7-segment scanner.
// Steps a saturating 3-bit index from button edges and multiplexes four digit codes onto the display.

// state | meaning
// DIG_0 | rightmost digit (n_0f) lit, an[0] low
// DIG_1 | digit 1 (n_1f) lit, an[1] low
// DIG_2 | digit 2 (n_2f) lit, an[2] low
// DIG_3 | leftmost digit (n_3f) lit, an[3] low
module control_display_frecuencia #(
    parameter int unsigned REFRESH_CYCLES = 50000,
    parameter logic [2:0]  INIT_FREQ      = 3'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [3:0] n_0f,
    input  logic [3:0] n_1f,
    input  logic [3:0] n_2f,
    input  logic [3:0] n_3f,
    output logic [2:0] indicadorFrecuencia,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        DIG_0 = 2'd0,
        DIG_1 = 2'd1,
        DIG_2 = 2'd2,
        DIG_3 = 2'd3
    } digit_t;

    digit_t           state;
    digit_t           state_nxt;
    logic [CNT_W-1:0] refresh_cnt;
    logic             refresh_wrap;
    logic [3:0]       digit_code;
    logic [3:0]       an_nxt;

    logic             btn_up_q;
    logic             btn_down_q;
    logic             up_p;
    logic             down_p;
    logic [2:0]       idx;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Dwell timer: each digit stays lit for REFRESH_CYCLES clocks.
    assign refresh_wrap = (refresh_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
        end else if (refresh_wrap) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DIG_0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        digit_code = 4'hF;
        an_nxt     = 4'b1111;
        case (state)
            DIG_0: begin
                digit_code = n_0f;
                an_nxt     = 4'b1110;
                if (refresh_wrap) state_nxt = DIG_1;
            end
            DIG_1: begin
                digit_code = n_1f;
                an_nxt     = 4'b1101;
                if (refresh_wrap) state_nxt = DIG_2;
            end
            DIG_2: begin
                digit_code = n_2f;
                an_nxt     = 4'b1011;
                if (refresh_wrap) state_nxt = DIG_3;
            end
            DIG_3: begin
                digit_code = n_3f;
                an_nxt     = 4'b0111;
                if (refresh_wrap) state_nxt = DIG_0;
            end
            default: begin
                state_nxt = DIG_0;
            end
        endcase
    end

    // Blank codes still assert the anode so every digit gets the same dwell time.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= an_nxt;
            seg <= seg_decode(digit_code);
        end
    end

    // History resets high so a button held through reset does not register as a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_up_q   <= 1'b1;
            btn_down_q <= 1'b1;
        end else begin
            btn_up_q   <= btn_up;
            btn_down_q <= btn_down;
        end
    end

    assign up_p   = btn_up & ~btn_up_q;
    assign down_p = btn_down & ~btn_down_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= INIT_FREQ;
        end else if (up_p && !down_p && (idx != 3'd7)) begin
            idx <= idx + 3'd1;
        end else if (down_p && !up_p && (idx != 3'd0)) begin
            idx <= idx - 3'd1;
        end
    end

    assign indicadorFrecuencia = idx;

endmodule

// File: tb/tb_control_display_frecuencia.sv
// Bench for control_display_frecuencia: digit-set table for the scanner plus
// hand-written button/reset sequences, all checked through an expectation queue.
module tb_control_display_frecuencia;

    localparam int RC = 4;

    logic       clk;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] n_0f, n_1f, n_2f, n_3f;
    logic [2:0] indicadorFrecuencia;
    logic [3:0] an;
    logic [6:0] seg;

    control_display_frecuencia #(
        .REFRESH_CYCLES(RC),
        .INIT_FREQ     (3'd0)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .btn_up             (btn_up),
        .btn_down           (btn_down),
        .n_0f               (n_0f),
        .n_1f               (n_1f),
        .n_2f               (n_2f),
        .n_3f               (n_3f),
        .indicadorFrecuencia(indicadorFrecuencia),
        .an                 (an),
        .seg                (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] n0, n1, n2, n3;
        logic [6:0] s0, s1, s2, s3;
    } row_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [2:0] ind;
    } exp_t;

    row_t       rows[3];
    exp_t       sb_q[$];
    logic [6:0] exp_seg_d[4];
    int         n_cmp;
    int         n_err;
    int         since_rel;
    int         tick_no;

    task automatic check(input string name, input int tk, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at tick %0d: got %b, expected %b", name, tk, act, req);
        end
    endtask

    task automatic load_row(input row_t r);
        n_0f = r.n0; n_1f = r.n1; n_2f = r.n2; n_3f = r.n3;
        exp_seg_d[0] = r.s0; exp_seg_d[1] = r.s1;
        exp_seg_d[2] = r.s2; exp_seg_d[3] = r.s3;
    endtask

    // Expected scan position is derived from the number of cycles since reset release.
    task automatic tick(input logic [2:0] exp_ind);
        exp_t e;
        exp_t got;
        int   d;
        if (reset) begin
            since_rel = 0;
            e.an  = 4'b1111;
            e.seg = 7'b1111111;
        end else begin
            since_rel++;
            d = ((since_rel - 1) / RC) % 4;
            e.an  = 4'b1111 ^ (4'b0001 << d);
            e.seg = exp_seg_d[d];
        end
        e.ind = exp_ind;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        tick_no++;
        got = sb_q.pop_front();
        check("an",  tick_no, {4'b0, an},                  {4'b0, got.an});
        check("seg", tick_no, {1'b0, seg},                 {1'b0, got.seg});
        check("ind", tick_no, {5'b0, indicadorFrecuencia}, {5'b0, got.ind});
    endtask

    initial begin
        n_cmp = 0; n_err = 0; since_rel = 0; tick_no = 0;
        rows[0] = '{n0: 4'd2, n1: 4'd5, n2: 4'd10, n3: 4'd1,
                    s0: 7'b0100100, s1: 7'b0010010, s2: 7'b1111111, s3: 7'b1111001};
        rows[1] = '{n0: 4'd0, n1: 4'd3, n2: 4'd4, n3: 4'd6,
                    s0: 7'b1000000, s1: 7'b0110000, s2: 7'b0011001, s3: 7'b0000010};
        rows[2] = '{n0: 4'd7, n1: 4'd8, n2: 4'd9, n3: 4'd15,
                    s0: 7'b1111000, s1: 7'b0000000, s2: 7'b0010000, s3: 7'b1111111};

        reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
        load_row(rows[0]);
        repeat (3) tick(3'd0);

        // Scanner table: full rotation plus return to digit 0 for each digit set.
        for (int r = 0; r < 3; r++) begin
            load_row(rows[r]);
            reset = 1'b1;
            tick(3'd0);
            reset = 1'b0;
            for (int c = 0; c < 4 * RC + 1; c++) tick(3'd0);
        end

        // Nine up presses saturate at 7, nine down presses saturate at 0.
        load_row(rows[0]);
        reset = 1'b1; tick(3'd0);
        reset = 1'b0; tick(3'd0);
        for (int i = 0; i < 9; i++) begin
            btn_up = 1'b1; tick(3'((i + 1 > 7) ? 7 : i + 1));
            btn_up = 1'b0; tick(3'((i + 1 > 7) ? 7 : i + 1));
        end
        for (int i = 0; i < 9; i++) begin
            btn_down = 1'b1; tick(3'((6 - i < 0) ? 0 : 6 - i));
            btn_down = 1'b0; tick(3'((6 - i < 0) ? 0 : 6 - i));
        end

        // Held button from index 3 yields one step.
        for (int i = 0; i < 3; i++) begin
            btn_up = 1'b1; tick(3'(i + 1));
            btn_up = 1'b0; tick(3'(i + 1));
        end
        btn_up = 1'b1;
        repeat (100) tick(3'd4);
        btn_up = 1'b0; tick(3'd4);

        // Simultaneous edges hold; a lone down edge still steps.
        btn_up = 1'b1; btn_down = 1'b1; tick(3'd4);
        btn_up = 1'b0; btn_down = 1'b0; tick(3'd4);
        btn_down = 1'b1; tick(3'd3);
        btn_down = 1'b0; tick(3'd3);

        // Button held across reset release gives no step.
        btn_up = 1'b1; reset = 1'b1; tick(3'd0);
        reset = 1'b0;
        repeat (5) tick(3'd0);
        btn_up = 1'b0; tick(3'd0);

        // Reset while digit 2 is lit and index is 5.
        reset = 1'b1; tick(3'd0);
        reset = 1'b0; tick(3'd0);
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1; tick(3'(i + 1));
            btn_up = 1'b0; tick(3'(i + 1));
        end
        reset = 1'b1; tick(3'd0);
        reset = 1'b0;
        repeat (6) tick(3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
